// File: rtl/conv2d_stream_engine.sv
// 3x3 streaming correlation over IMG_W x IMG_H raster frames; emits only valid-region results.
// Latency: result 2 edges after its completing pixel; no backpressure, downstream always accepts.
module conv2d_stream_engine #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int OUT_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_st,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] din,
  input  logic              coef_we,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_din,
  output logic              busy,
  output logic              out_valid,
  output logic [OUT_W-1:0]  dout,
  output logic              out_st,
  output logic              out_last
);

  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int PROD_W = DATA_W + COEF_W;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   col, col_nxt, pc;
  logic [RW-1:0]   row, row_nxt, pr;
  logic            flush_cnt, flush_nxt;
  logic            accept, restart, win_done;

  logic signed [COEF_W-1:0] coef [9];
  logic [DATA_W-1:0]        lb0 [IMG_W];
  logic [DATA_W-1:0]        lb1 [IMG_W];
  logic [DATA_W-1:0]        win [9];
  logic signed [PROD_W-1:0] prod [9];
  logic signed [OUT_W-1:0]  acc;
  logic                     v0, st0, last0, v1, st1, last1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      flush_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      flush_cnt <= flush_nxt;
    end
  end

  // pc/pr are the raster position of the pixel on din this cycle
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    flush_nxt = flush_cnt;
    accept    = 1'b0;
    restart   = 1'b0;
    pc        = col;
    pr        = row;
    unique case (state)
      IDLE: begin
        if (in_valid && in_st) begin
          accept    = 1'b1;
          restart   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          accept  = 1'b1;
          restart = in_st;
        end
      end
      FLUSH: begin
        flush_nxt = 1'b1;
        if (flush_cnt) begin
          state_nxt = IDLE;
          flush_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (restart) begin
      pc = '0;
      pr = '0;
    end
    if (accept) begin
      if (pc == CW'(IMG_W - 1)) begin
        col_nxt = '0;
        row_nxt = pr + RW'(1);
        if (pr == RW'(IMG_H - 1)) state_nxt = FLUSH;
      end else begin
        col_nxt = pc + CW'(1);
        row_nxt = pr;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign win_done = accept && (pr >= RW'(2)) && (pc >= CW'(2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) coef[k] <= (k == 4) ? COEF_W'(1) : '0;
    end else if (coef_we && (state == IDLE) && (coef_addr <= 4'd8)) begin
      coef[coef_addr] <= coef_din;
    end
  end

  // Line buffers hold the two previous rows; stale contents never reach a valid window
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[pc] <= lb0[pc];
      lb0[pc] <= din;
      for (int r = 0; r < 3; r++) begin
        win[r*3]   <= win[r*3+1];
        win[r*3+1] <= win[r*3+2];
      end
      win[2] <= lb1[pc];
      win[5] <= lb0[pc];
      win[8] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (v0) begin
      for (int k = 0; k < 9; k++)
        prod[k] <= $signed({{COEF_W{1'b0}}, win[k]}) * PROD_W'(coef[k]);
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < 9; k++) acc = acc + OUT_W'(prod[k]);
  end

  // A restart kills anything still in the product or sum stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0        <= 1'b0;
      st0       <= 1'b0;
      last0     <= 1'b0;
      v1        <= 1'b0;
      st1       <= 1'b0;
      last1     <= 1'b0;
      out_valid <= 1'b0;
      out_st    <= 1'b0;
      out_last  <= 1'b0;
      dout      <= '0;
    end else begin
      v0        <= win_done;
      st0       <= win_done && (pr == RW'(2)) && (pc == CW'(2));
      last0     <= win_done && (pr == RW'(IMG_H - 1)) && (pc == CW'(IMG_W - 1));
      v1        <= v0 && !restart;
      st1       <= st0;
      last1     <= last0;
      out_valid <= v1 && !restart;
      out_st    <= v1 && st1 && !restart;
      out_last  <= v1 && last1 && !restart;
      if (v1) dout <= acc;
    end
  end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Self-checking bench for conv2d_stream_engine: directed frames plus randomized frames
// checked against a scoreboard built from plain window arithmetic.
module tb_conv2d_stream_engine;
  localparam int DW = 8, CWI = 8, W = 8, H = 8, OW = 20;
  localparam int NPIX = W * H, NOUT = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic rst_n, in_st, in_valid, coef_we, busy, out_valid, out_st, out_last;
  logic [DW-1:0]  din;
  logic [3:0]     coef_addr;
  logic [CWI-1:0] coef_din;
  logic [OW-1:0]  dout;

  conv2d_stream_engine #(.DATA_W(DW), .COEF_W(CWI), .IMG_W(W), .IMG_H(H), .OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .in_st(in_st), .in_valid(in_valid), .din(din),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_din(coef_din),
    .busy(busy), .out_valid(out_valid), .dout(dout), .out_st(out_st), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [OW-1:0] val;
    logic          st;
    logic          last;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_FLUSH} phase_t;

  exp_t   expq[$];
  int     tests = 0, fails = 0, edge_n = 0, frame_outs = 0;
  int     mcoef[9];
  int     img[H][W];
  int     src[NPIX];
  int     mr, mc, mflush;
  bit     m_busy;
  phase_t ph;

  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    ph = M_IDLE;
    m_busy = 1'b0;
    mr = 0;
    mc = 0;
    for (int k = 0; k < 9; k++) mcoef[k] = (k == 4) ? 1 : 0;
  endtask

  // Record a pixel at (r,c); a pixel completing a full 3x3 window schedules a result 2 edges later
  task automatic accept_pix(int r, int c, int pix);
    int s;
    img[r][c] = pix;
    if (r >= 2 && c >= 2) begin
      exp_t e;
      s = 0;
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          s += mcoef[dr*3+dc] * img[r-2+dr][c-2+dc];
      e.due  = edge_n + 2;
      e.val  = OW'(s);
      e.st   = (r == 2 && c == 2);
      e.last = (r == H - 1 && c == W - 1);
      expq.push_back(e);
    end
    if (c == W - 1) begin
      mc = 0;
      mr = r + 1;
      if (r == H - 1) begin
        ph = M_FLUSH;
        mflush = 2;
      end
    end else begin
      mc = c + 1;
      mr = r;
    end
  endtask

  task automatic model_edge(bit v, bit st, int pix, bit we, int addr, int cd);
    logic signed [CWI-1:0] cv;
    if (we && !m_busy && addr <= 8) begin
      cv = CWI'(cd);
      mcoef[addr] = cv;
    end
    if (ph == M_FLUSH) begin
      mflush--;
      if (mflush == 0) begin
        ph = M_IDLE;
        m_busy = 1'b0;
      end
    end else if (v && st) begin
      expq.delete();
      ph = M_RUN;
      m_busy = 1'b1;
      accept_pix(0, 0, pix);
    end else if (v && ph == M_RUN) begin
      accept_pix(mr, mc, pix);
    end
  endtask

  task automatic step(bit v, bit st, int pix, bit we = 1'b0, int addr = 0, int cd = 0);
    in_valid  = v;
    in_st     = st;
    din       = DW'(pix);
    coef_we   = we;
    coef_addr = 4'(addr);
    coef_din  = CWI'(cd);
    @(posedge clk);
    edge_n++;
    if (!rst_n) model_reset();
    else model_edge(v, st, pix, we, addr, cd);
    #1;
  endtask

  task automatic load_kernel(int k0, int kall);
    for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 0, 1'b1, k, (k == 0) ? k0 : kall);
  endtask

  task automatic load_identity();
    for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 0, 1'b1, k, (k == 4) ? 1 : 0);
  endtask

  // mode 0: contiguous, 1: in_valid low every 3rd cycle, 2: random bubbles and stray in_st
  task automatic run_frame(int mode, int npix, bit busy_wr);
    int i = 0;
    int cyc = 0;
    bit v;
    while (i < npix && cyc < 2000) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = (cyc % 3 != 2);
      else v = ($urandom_range(0, 2) != 0);
      if (v) begin
        step(1'b1, i == 0, src[i], busy_wr && i == 10, 0, 5);
        i++;
      end else begin
        step(1'b0, (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0, int'($urandom_range(0, 255)));
      end
      cyc++;
    end
    if (i < npix) check("frame_timeout", i, npix);
  endtask

  task automatic drain();
    repeat (6) step(1'b0, 1'b0, 0);
  endtask

  task automatic ramp();
    for (int i = 0; i < NPIX; i++) src[i] = i;
  endtask

  always @(negedge clk) begin
    check("busy", busy, m_busy);
    if (out_valid === 1'b1) begin
      frame_outs++;
      if (expq.size() == 0) begin
        check("spurious_valid", out_valid, 1'b0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("latency_edge", edge_n, e.due);
        check("dout", dout, e.val);
        check("out_st", out_st, e.st);
        check("out_last", out_last, e.last);
      end
    end else if (expq.size() > 0 && expq[0].due <= edge_n) begin
      check("missing_valid", out_valid, 1'b1);
      void'(expq.pop_front());
    end
  end

  initial begin
    in_valid = 1'b0; in_st = 1'b0; din = '0;
    coef_we = 1'b0; coef_addr = '0; coef_din = '0;
    model_reset();

    rst_n = 1'b0;
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    rst_n = 1'b1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dout", dout, '0);
    check("rst_out_st", out_st, 1'b0);
    check("rst_out_last", out_last, 1'b0);

    // T1: identity kernel, contiguous ramp
    ramp();
    frame_outs = 0;
    run_frame(0, NPIX, 1'b0);
    drain();
    check("t1_count", frame_outs, NOUT);

    // T2: all +1 on saturated image, then all -128
    for (int i = 0; i < NPIX; i++) src[i] = 255;
    load_kernel(1, 1);
    frame_outs = 0;
    run_frame(0, NPIX, 1'b0);
    drain();
    check("t2a_count", frame_outs, NOUT);
    load_kernel(128, 128);
    frame_outs = 0;
    run_frame(0, NPIX, 1'b0);
    drain();
    check("t2b_count", frame_outs, NOUT);

    // T3: ramp with a bubble every third cycle
    load_identity();
    ramp();
    frame_outs = 0;
    run_frame(1, NPIX, 1'b0);
    drain();
    check("t3_count", frame_outs, NOUT);

    // T4: restart on pixel 30; 8 first-frame results leave before the restart, then 36
    frame_outs = 0;
    run_frame(0, 30, 1'b0);
    run_frame(0, NPIX, 1'b0);
    drain();
    check("t4_count", frame_outs, 8 + NOUT);

    // T5: busy write ignored, then idle writes to addr 0 and out-of-range addr 9
    frame_outs = 0;
    run_frame(0, NPIX, 1'b1);
    drain();
    check("t5a_count", frame_outs, NOUT);
    step(1'b0, 1'b0, 0, 1'b1, 0, 5);
    step(1'b0, 1'b0, 0, 1'b1, 9, 7);
    frame_outs = 0;
    run_frame(0, NPIX, 1'b0);
    drain();
    check("t5b_count", frame_outs, NOUT);

    // T6: reset mid-frame restores identity kernel and silences outputs
    load_kernel(3, -2);
    run_frame(0, 40, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 0);
    rst_n = 1'b1;
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_dout", dout, '0);
    check("t6_busy", busy, 1'b0);
    drain();
    frame_outs = 0;
    run_frame(0, NPIX, 1'b0);
    drain();
    check("t6_count", frame_outs, NOUT);

    // T7: random kernels, images and bubbles
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 0, 1'b1, k, int'($urandom_range(0, 255)));
      for (int i = 0; i < NPIX; i++) src[i] = int'($urandom_range(0, 255));
      frame_outs = 0;
      run_frame(2, NPIX, 1'b0);
      drain();
      check("t7_count", frame_outs, NOUT);
    end

    check("queue_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
